secded_dec_pipe: RTL and testbench

Three-stage pipelined SEC-DED decoder for the extended Hamming (12,7) code. It sits directly downstream of the error-injection XOR stage. Each cycle it consumes one received 12-bit codeword and returns the corrected 7-bit data word, a correction status and the syndrome. It adds a valid/ready handshake with full-pipeline backpressure and saturating error-statistics counters.

---
 rtl/secded_dec_pipe.sv | 126 ++++++++++++
 tb/tb_secded_dec_pipe.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secded_dec_pipe.sv
// rtl/secded_dec_pipe.sv - three-stage SEC-DED (12,7) extended Hamming decoder with stall and error counters
module secded_dec_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      in_cw,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       out_data,
    output logic             out_corr,
    output logic             out_uncorr,
    output logic [3:0]       out_synd,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    logic             w_en;
    logic             w_hs;
    logic [3:0]       w_synd;
    logic             w_par;
    logic             w_flip;
    logic [10:0]      w_fix_mask;
    logic [10:0]      w_fixed;
    logic [6:0]       w_data;
    logic             w_corr;
    logic             w_uncorr;

    logic             r_s1_v;
    logic [11:0]      r_s1_cw;
    logic             r_s2_v;
    logic [11:0]      r_s2_cw;
    logic [3:0]       r_s2_synd;
    logic             r_s2_p;
    logic             r_out_valid;
    logic [6:0]       r_out_data;
    logic             r_out_corr;
    logic             r_out_uncorr;
    logic [3:0]       r_out_synd;
    logic [CNT_W-1:0] r_corr_cnt;
    logic [CNT_W-1:0] r_uncorr_cnt;

    assign w_en     = !r_out_valid || out_ready;
    assign w_hs     = r_out_valid && out_ready;
    assign in_ready = w_en;

    // Masks select the in_cw bits whose Hamming position has syndrome bit k set.
    assign w_synd[0] = ^(r_s1_cw[10:0] & 11'h555);
    assign w_synd[1] = ^(r_s1_cw[10:0] & 11'h666);
    assign w_synd[2] = ^(r_s1_cw[10:0] & 11'h078);
    assign w_synd[3] = ^(r_s1_cw[10:0] & 11'h780);
    assign w_par     = ^r_s1_cw;

    assign w_flip   = r_s2_p && (r_s2_synd != 4'd0) && (r_s2_synd <= 4'd11);
    assign w_corr   = r_s2_p && (r_s2_synd <= 4'd11);
    assign w_uncorr = (r_s2_p && (r_s2_synd >= 4'd12)) || (!r_s2_p && (r_s2_synd != 4'd0));

    always_comb begin
        w_fix_mask = 11'd0;
        if (w_flip) begin
            w_fix_mask = 11'd1 << (r_s2_synd - 4'd1);
        end
    end

    assign w_fixed = r_s2_cw[10:0] ^ w_fix_mask;
    assign w_data  = {w_fixed[10], w_fixed[9], w_fixed[8], w_fixed[6],
                      w_fixed[5], w_fixed[4], w_fixed[2]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_v       <= 1'b0;
            r_s1_cw      <= 12'd0;
            r_s2_v       <= 1'b0;
            r_s2_cw      <= 12'd0;
            r_s2_synd    <= 4'd0;
            r_s2_p       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= 7'd0;
            r_out_corr   <= 1'b0;
            r_out_uncorr <= 1'b0;
            r_out_synd   <= 4'd0;
        end else if (w_en) begin
            r_s1_v       <= in_valid;
            r_s1_cw      <= in_cw;
            r_s2_v       <= r_s1_v;
            r_s2_cw      <= r_s1_cw;
            r_s2_synd    <= w_synd;
            r_s2_p       <= w_par;
            r_out_valid  <= r_s2_v;
            r_out_data   <= w_data;
            r_out_corr   <= w_corr;
            r_out_uncorr <= w_uncorr;
            r_out_synd   <= r_s2_synd;
        end
    end

    // Counters only see delivered words, so bubbles and stalled words never count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (clr_cnt) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (w_hs) begin
            if (r_out_corr && !(&r_corr_cnt)) begin
                r_corr_cnt <= r_corr_cnt + 1'b1;
            end
            if (r_out_uncorr && !(&r_uncorr_cnt)) begin
                r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_corr   = r_out_corr;
    assign out_uncorr = r_out_uncorr;
    assign out_synd   = r_out_synd;
    assign corr_cnt   = r_corr_cnt;
    assign uncorr_cnt = r_uncorr_cnt;

endmodule

// File: tb/tb_secded_dec_pipe.sv
// tb/tb_secded_dec_pipe.sv - self-checking bench for secded_dec_pipe
`timescale 1ns/1ps
module tb_secded_dec_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [11:0] in_cw;
    logic        out_ready;
    logic        clr_cnt;
    wire         in_ready;
    wire         out_valid;
    wire  [6:0]  out_data;
    wire         out_corr;
    wire         out_uncorr;
    wire  [3:0]  out_synd;
    wire  [15:0] corr_cnt;
    wire  [15:0] uncorr_cnt;
    wire         n_in_ready;
    wire         n_out_valid;
    wire  [6:0]  n_out_data;
    wire         n_out_corr;
    wire         n_out_uncorr;
    wire  [3:0]  n_out_synd;
    wire  [1:0]  n_corr_cnt;
    wire  [1:0]  n_uncorr_cnt;

    always #5 clk = ~clk;

    secded_dec_pipe u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_corr(out_corr),
        .out_uncorr(out_uncorr), .out_synd(out_synd), .clr_cnt(clr_cnt),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    secded_dec_pipe #(.CNT_W(2)) u_dut_n (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(n_in_ready), .in_cw(in_cw),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data), .out_corr(n_out_corr),
        .out_uncorr(n_out_uncorr), .out_synd(n_out_synd), .clr_cnt(clr_cnt),
        .corr_cnt(n_corr_cnt), .uncorr_cnt(n_uncorr_cnt)
    );

    typedef struct {
        logic [6:0] data;
        logic       corr;
        logic       uncorr;
        logic [3:0] synd;
    } exp_t;

    typedef struct {
        logic [11:0] cw;
        exp_t        e;
    } vec_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   chk_lat = 1'b0;
    exp_t q[$];
    int   q_t[$];
    exp_t cur_exp;
    exp_t pe;
    int   pt;
    int   mc16, mu16, mc2, mu2;
    bit   prev_stall = 1'b0;
    logic [13:0] prev_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int dpos(input int j);
        case (j)
            0: return 3;
            1: return 5;
            2: return 6;
            3: return 7;
            4: return 9;
            5: return 10;
            default: return 11;
        endcase
    endfunction

    // Parity bits are chosen so that the XOR of all set positions is zero.
    function automatic logic [11:0] encode(input logic [6:0] d);
        logic [11:0] cw;
        int sx;
        cw = '0;
        sx = 0;
        for (int j = 0; j < 7; j++) begin
            if (d[j]) begin
                cw[dpos(j)-1] = 1'b1;
                sx = sx ^ dpos(j);
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (sx[k]) cw[(1 << k) - 1] = 1'b1;
        end
        cw[11] = ^cw[10:0];
        return cw;
    endfunction

    function automatic logic [6:0] extract(input logic [11:0] cw);
        logic [6:0] d;
        for (int j = 0; j < 7; j++) d[j] = cw[dpos(j)-1];
        return d;
    endfunction

    task automatic gen(input int nerr, output logic [11:0] cw, output exp_t e);
        logic [6:0] d;
        int q1, q2;
        d  = 7'($urandom);
        cw = encode(d);
        q1 = $urandom_range(1, 12);
        q2 = q1;
        while (q2 == q1) q2 = $urandom_range(1, 12);
        e.data = d; e.corr = 1'b0; e.uncorr = 1'b0; e.synd = 4'd0;
        if (nerr >= 1) begin
            cw[q1-1] = ~cw[q1-1];
            e.corr   = 1'b1;
            e.synd   = (q1 == 12) ? 4'd0 : 4'(q1);
        end
        if (nerr == 2) begin
            cw[q2-1] = ~cw[q2-1];
            e.corr   = 1'b0;
            e.uncorr = 1'b1;
            e.synd   = e.synd ^ ((q2 == 12) ? 4'd0 : 4'(q2));
            e.data   = extract(cw);
        end
    endtask

    function automatic int sat_inc(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            q.delete();
            q_t.delete();
            mc16 = 0; mu16 = 0; mc2 = 0; mu2 = 0;
            prev_stall = 1'b0;
        end else begin
            check("corr_cnt", 32'(corr_cnt), 32'(mc16));
            check("uncorr_cnt", 32'(uncorr_cnt), 32'(mu16));
            check("corr_cnt_w2", 32'(n_corr_cnt), 32'(mc2));
            check("uncorr_cnt_w2", 32'(n_uncorr_cnt), 32'(mu2));
            if (out_valid && !out_ready) check("in_ready_stall", 32'(in_ready), 32'd0);
            if (prev_stall) check("hold_outputs", 32'({out_valid, out_data, out_corr, out_uncorr, out_synd}), 32'(prev_out));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: got data 0x%0h, expected no word", out_data);
                end else begin
                    pe = q.pop_front();
                    pt = q_t.pop_front();
                    check("out_data", 32'(out_data), 32'(pe.data));
                    check("out_corr", 32'(out_corr), 32'(pe.corr));
                    check("out_uncorr", 32'(out_uncorr), 32'(pe.uncorr));
                    check("out_synd", 32'(out_synd), 32'(pe.synd));
                    if (chk_lat) check("latency", 32'(cyc - pt), 32'd3);
                end
            end
            if (clr_cnt) begin
                mc16 = 0; mu16 = 0; mc2 = 0; mu2 = 0;
            end else if (out_valid && out_ready) begin
                if (out_corr) begin
                    mc16 = sat_inc(mc16, 65535);
                    mc2  = sat_inc(mc2, 3);
                end
                if (out_uncorr) begin
                    mu16 = sat_inc(mu16, 65535);
                    mu2  = sat_inc(mu2, 3);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(cur_exp);
                q_t.push_back(cyc);
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_valid, out_data, out_corr, out_uncorr, out_synd};
        end
    end

    task automatic send(input logic [11:0] cw, input exp_t e);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_cw    = cw;
        cur_exp  = e;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck at 0 for cw 0x%0h, expected accept", cw);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 100 && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drained", 32'(q.size()), 32'd0);
    endtask

    task automatic pulse_clr();
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
    endtask

    vec_t        vt[9];
    logic [11:0] rcw;
    exp_t        re;
    bit          rnd_done;
    int          wait_n;

    initial begin
        vt[0] = '{12'h807, '{7'h01, 1'b0, 1'b0, 4'h0}};
        vt[1] = '{12'h817, '{7'h01, 1'b1, 1'b0, 4'h5}};
        vt[2] = '{12'h007, '{7'h01, 1'b1, 1'b0, 4'h0}};
        vt[3] = '{12'h804, '{7'h01, 1'b0, 1'b1, 4'h3}};
        vt[4] = '{12'h888, '{7'h00, 1'b0, 1'b1, 4'hC}};
        vt[5] = '{12'h000, '{7'h00, 1'b0, 1'b0, 4'h0}};
        vt[6] = '{12'hFFF, '{7'h7F, 1'b0, 1'b0, 4'h0}};
        vt[7] = '{12'hBFF, '{7'h7F, 1'b1, 1'b0, 4'hB}};
        vt[8] = '{12'hFDF, '{7'h7F, 1'b1, 1'b0, 4'h6}};

        reset = 1'b0; in_valid = 1'b0; in_cw = '0; out_ready = 1'b1; clr_cnt = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outputs", 32'({out_data, out_corr, out_uncorr, out_synd}), 32'd0);
        check("rst_counters", 32'({corr_cnt, uncorr_cnt}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;

        chk_lat = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send(vt[i].cw, vt[i].e);
            idle(4);
        end
        check("tbl_corr_cnt", 32'(corr_cnt), 32'd4);
        check("tbl_uncorr_cnt", 32'(uncorr_cnt), 32'd2);
        chk_lat = 1'b0;
        pulse_clr();

        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    gen($urandom_range(0, 1), rcw, re);
                    send(rcw, re);
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        pulse_clr();

        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    gen($urandom_range(0, 2), rcw, re);
                    send(rcw, re);
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        pulse_clr();

        for (int i = 0; i < 5; i++) begin
            gen(1, rcw, re);
            send(rcw, re);
        end
        drain();
        check("sat_corr_w2", 32'(n_corr_cnt), 32'd3);
        check("sat_corr_w16", 32'(corr_cnt), 32'd5);

        send(12'h817, vt[1].e);
        in_valid = 1'b0;
        wait_n = 0;
        while (!out_valid && wait_n < 20) begin
            @(posedge clk);
            #1;
            wait_n++;
        end
        check("clr_wait_out_valid", 32'(out_valid), 32'd1);
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        check("clr_wins_w16", 32'(corr_cnt), 32'd0);
        check("clr_wins_w2", 32'(n_corr_cnt), 32'd0);

        for (int i = 0; i < 4; i++) send(vt[1].cw, vt[1].e);
        in_valid = 1'b0;
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_counters", 32'({corr_cnt, uncorr_cnt}), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        chk_lat = 1'b1;
        send(vt[3].cw, vt[3].e);
        idle(6);
        drain();
        chk_lat = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
